c17_bist: RTL and testbench

Built-in self-test driver/checker for the c17 combinational block. Exhaustively drives all 32 input patterns onto c17's primary inputs from a registered counter and samples its two primary outputs. It accumulates three response counts, compares them against expected values, and reports pass/fail over a start/done handshake. It sits on the far side of the c17 pins: its outputs are c17's inputs and its inputs are c17's outputs.

---
 rtl/c17_bist.sv | 127 ++++++++++++
 tb/tb_c17_bist.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_bist.sv
// Exhaustive BIST driver/checker for the c17 block: walks all 32 input patterns,
// counts the responses on nx22/nx23 and reports pass/fail over a start/done handshake.
module c17_bist #(
  parameter int unsigned HOLD       = 2,
  parameter int unsigned EXP_ONES22 = 18,
  parameter int unsigned EXP_ONES23 = 18,
  parameter int unsigned EXP_BOTH   = 13
) (
  input  logic       blif_clk_net,
  input  logic       blif_reset_net,
  input  logic       start,
  input  logic       nx22,
  input  logic       nx23,
  output logic       nx1,
  output logic       nx2,
  output logic       nx3,
  output logic       nx6,
  output logic       nx7,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] ones22,
  output logic [5:0] ones23,
  output logic [5:0] both
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  typedef struct packed {
    logic [5:0] o22;
    logic [5:0] o23;
    logic [5:0] both;
  } cnt_t;

  localparam logic [3:0] H_LAST = 4'(HOLD - 1);
  localparam logic [5:0] E22    = 6'(EXP_ONES22);
  localparam logic [5:0] E23    = 6'(EXP_ONES23);
  localparam logic [5:0] EBOTH  = 6'(EXP_BOTH);

  state_e     state_q, state_d;
  logic [4:0] p_q, p_d;
  logic [4:0] pins_q, pins_d;
  logic [3:0] h_q, h_d;
  cnt_t       cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       last_hold;

  assign last_hold = (h_q == H_LAST);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          p_d     = '0;
          h_d     = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (last_hold) begin
          // Response sampled at the last edge of the hold window, then advance.
          cnt_d.o22  = cnt_q.o22 + {5'd0, nx22};
          cnt_d.o23  = cnt_q.o23 + {5'd0, nx23};
          cnt_d.both = cnt_q.both + {5'd0, nx22 & nx23};
          p_d        = p_q + 5'd1;
          h_d        = '0;
          if (p_q == 5'd31) begin
            state_d = S_DONE;
            pass_d  = (cnt_d.o22 == E22) && (cnt_d.o23 == E23) && (cnt_d.both == EBOTH);
          end
        end else begin
          h_d = h_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Output flops are loaded from next-state so pins/flags are fully registered.
    busy_d = (state_d == S_DRIVE);
    done_d = (state_d == S_DONE);
    pins_d = busy_d ? p_d : 5'd0;
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      h_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pins_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pins_q  <= pins_d;
    end
  end

  assign nx1    = pins_q[0];
  assign nx2    = pins_q[1];
  assign nx3    = pins_q[2];
  assign nx6    = pins_q[3];
  assign nx7    = pins_q[4];
  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;
  assign ones22 = cnt_q.o22;
  assign ones23 = cnt_q.o23;
  assign both   = cnt_q.both;

endmodule

// File: tb/tb_c17_bist.sv
// Bench for c17_bist: a c17 plant model with injectable faults closes the loop;
// expected counts come from enumerating all 32 patterns through the plant model.
module tb_c17_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  // fault controls applied to the plant outputs
  bit          f_stuck22 = 1'b0;
  logic [31:0] f_m22 = '0, f_m23 = '0;

  int n_chk = 0, n_fail = 0;

  // c17 netlist as a behavioural plant: returns {N23, N22}
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[0] & p[2]);
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11);
    n19 = ~(n11 & p[4]);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic void model(input bit st, input logic [31:0] m22, input logic [31:0] m23,
                                output int e22, output int e23, output int eb);
    e22 = 0; e23 = 0; eb = 0;
    for (int k = 0; k < 32; k++) begin
      logic [1:0] r;
      logic a, b;
      r = c17(5'(k));
      a = st ? 1'b0 : (r[0] ^ m22[k]);
      b = r[1] ^ m23[k];
      e22 += int'(a);
      e23 += int'(b);
      eb  += int'(a & b);
    end
  endfunction

  // HOLD=2 instance
  logic nx1_2, nx2_2, nx3_2, nx6_2, nx7_2, busy2, done2, pass2, nx22_2, nx23_2;
  logic [5:0] o22_2, o23_2, ob_2;
  logic [4:0] pins2;
  logic [1:0] r2;
  assign pins2  = {nx7_2, nx6_2, nx3_2, nx2_2, nx1_2};
  assign r2     = c17(pins2);
  assign nx22_2 = f_stuck22 ? 1'b0 : (r2[0] ^ f_m22[pins2]);
  assign nx23_2 = r2[1] ^ f_m23[pins2];

  c17_bist #(.HOLD(2)) dut2 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start2),
    .nx22(nx22_2), .nx23(nx23_2),
    .nx1(nx1_2), .nx2(nx2_2), .nx3(nx3_2), .nx6(nx6_2), .nx7(nx7_2),
    .busy(busy2), .done(done2), .pass(pass2),
    .ones22(o22_2), .ones23(o23_2), .both(ob_2)
  );

  // HOLD=1 instance
  logic nx1_1, nx2_1, nx3_1, nx6_1, nx7_1, busy1, done1, pass1, nx22_1, nx23_1;
  logic [5:0] o22_1, o23_1, ob_1;
  logic [4:0] pins1;
  logic [1:0] r1;
  assign pins1  = {nx7_1, nx6_1, nx3_1, nx2_1, nx1_1};
  assign r1     = c17(pins1);
  assign nx22_1 = f_stuck22 ? 1'b0 : (r1[0] ^ f_m22[pins1]);
  assign nx23_1 = r1[1] ^ f_m23[pins1];

  c17_bist #(.HOLD(1)) dut1 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start1),
    .nx22(nx22_1), .nx23(nx23_1),
    .nx1(nx1_1), .nx2(nx2_1), .nx3(nx3_1), .nx6(nx6_1), .nx7(nx7_1),
    .busy(busy1), .done(done1), .pass(pass1),
    .ones22(o22_1), .ones23(o23_1), .both(ob_1)
  );

  logic [25:0] all2, all1;
  assign all2 = {pins2, busy2, done2, pass2, o22_2, o23_2, ob_2};
  assign all1 = {pins1, busy1, done1, pass1, o22_1, o23_1, ob_1};

  // One full HOLD=2 run with per-cycle pin/flag checks and end-of-run result checks.
  task automatic run_h2(input bit reassert, input bit st, input logic [31:0] m22,
                        input logic [31:0] m23, input string tag);
    int e22, e23, eb;
    logic ep;
    f_stuck22 = st; f_m22 = m22; f_m23 = m23;
    model(st, m22, m23, e22, e23, eb);
    ep = (e22 == 18) && (e23 == 18) && (eb == 13);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n_chk++;
    if ({pass2, o22_2, o23_2, ob_2} !== 19'd0) begin
      n_fail++;
      $display("FAIL %s clear_on_start: got %h want 0", tag, {pass2, o22_2, o23_2, ob_2});
    end
    for (int j = 1; j <= 64; j++) begin
      if (j > 1) @(negedge clk);
      start2 = reassert && (j == 10);
      n_chk++;
      if ({busy2, done2, pins2} !== {1'b1, 1'b0, 5'((j - 1) / 2)}) begin
        n_fail++;
        $display("FAIL %s pins cyc%0d: got %b want %b", tag, j, {busy2, done2, pins2},
                 {1'b1, 1'b0, 5'((j - 1) / 2)});
      end
    end
    @(negedge clk);
    start2 = reassert;
    n_chk++;
    if ({busy2, done2, pins2, pass2, o22_2, o23_2, ob_2} !==
        {1'b0, 1'b1, 5'd0, ep, 6'(e22), 6'(e23), 6'(eb)}) begin
      n_fail++;
      $display("FAIL %s done_cyc65: got b%b d%b p%0d pass%b %0d/%0d/%0d want b0 d1 p0 pass%b %0d/%0d/%0d",
               tag, busy2, done2, pins2, pass2, o22_2, o23_2, ob_2, ep, e22, e23, eb);
    end
    @(negedge clk); start2 = 1'b0;
    n_chk++;
    if ({busy2, done2} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s after_done: got %b want 00", tag, {busy2, done2});
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy2, done2, pass2, o22_2, o23_2, ob_2} !== {2'b00, ep, 6'(e22), 6'(e23), 6'(eb)}) begin
      n_fail++;
      $display("FAIL %s held: got %b %0d/%0d/%0d pass%b want pass%b %0d/%0d/%0d", tag,
               {busy2, done2}, o22_2, o23_2, ob_2, pass2, ep, e22, e23, eb);
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({all2, all1} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", {all2, all1});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fault_free();
    run_h2(1'b0, 1'b0, 32'h0, 32'h0, "fault_free");
    n_chk++;
    if ({o22_2, o23_2, ob_2, pass2} !== {6'd18, 6'd18, 6'd13, 1'b1}) begin
      n_fail++;
      $display("FAIL fault_free_golden: got %0d/%0d/%0d pass%b want 18/18/13 pass1",
               o22_2, o23_2, ob_2, pass2);
    end
  endtask

  task automatic test_stuck22();
    run_h2(1'b0, 1'b1, 32'h0, 32'h0, "stuck22");
    n_chk++;
    if ({o22_2, o23_2, ob_2, pass2} !== {6'd0, 6'd18, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck22_golden: got %0d/%0d/%0d pass%b want 0/18/0 pass0",
               o22_2, o23_2, ob_2, pass2);
    end
  endtask

  task automatic test_inverted23();
    run_h2(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, "inv23");
    n_chk++;
    if ({o23_2, pass2} !== {6'd14, 1'b0}) begin
      n_fail++;
      $display("FAIL inv23_golden: got ones23=%0d pass%b want 14 pass0", o23_2, pass2);
    end
  endtask

  task automatic test_restart_ignored();
    run_h2(1'b1, 1'b0, 32'h0, 32'h0, "restart_ignored");
  endtask

  task automatic test_hold1();
    f_stuck22 = 1'b0; f_m22 = '0; f_m23 = '0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      if (j > 1) @(negedge clk);
      n_chk++;
      if ({busy1, done1, pins1} !== {1'b1, 1'b0, 5'(j - 1)}) begin
        n_fail++;
        $display("FAIL hold1 pins cyc%0d: got %b want %b", j, {busy1, done1, pins1},
                 {1'b1, 1'b0, 5'(j - 1)});
      end
    end
    @(negedge clk);
    n_chk++;
    if ({busy1, done1, pass1, o22_1, o23_1, ob_1} !== {1'b0, 1'b1, 1'b1, 6'd18, 6'd18, 6'd13}) begin
      n_fail++;
      $display("FAIL hold1 done_cyc33: got b%b d%b pass%b %0d/%0d/%0d want b0 d1 pass1 18/18/13",
               busy1, done1, pass1, o22_1, o23_1, ob_1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    f_stuck22 = 1'b0; f_m22 = '0; f_m23 = '0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (19) @(negedge clk);
    n_chk++;
    if ({busy2, pins2} !== {1'b1, 5'd9}) begin
      n_fail++;
      $display("FAIL midrun_pre: got %b want %b", {busy2, pins2}, {1'b1, 5'd9});
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (all2 !== 26'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h want 0", all2);
    end
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_chk++;
      if ({busy2, done2} !== 2'b00) begin
        n_fail++;
        $display("FAIL midrun_no_done cyc%0d: got %b want 00", j, {busy2, done2});
      end
    end
    run_h2(1'b0, 1'b0, 32'h0, 32'h0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i == 3) begin a = '0; b = 32'h1 << $urandom_range(31); end
      run_h2(1'($urandom_range(1)), 1'b0, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck22();
    test_hold1();
    test_restart_ignored();
    test_reset_midrun();
    test_inverted23();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
